multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 15: maximum cycles spent waiting on mem_ready before timeout.
REQ-002 clk  input  1  rising-edge clock; the block has one clock.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 instruc  input  32  instruction register contents.
- Fields: opcode=[6:0], funct3=[14:12], funct7=[31:25].
REQ-005 mem_ready  input  1  memory done; samples high in the last cycle of an access.
REQ-006 zero  input  1  ALU zero flag, valid in BRANCH.
REQ-007 pc_write  output  1  PC register load enable.
REQ-008 ir_write  output  1  instruction register load enable.
REQ-009 mem_read / mem_write  output  1 each  memory strobes.
REQ-010 reg_write  output  1  register file write enable.
REQ-011 alu_src_a  output  2  ALU A select: 0=PC, 1=rs1, 2=old PC.
REQ-012 alu_src_b  output  2  ALU B select: 0=rs2, 1=imm, 2=const 4.
REQ-013 alu_op  output  2  ALU op class: 0=add, 1=sub/compare, 2=funct-decoded.
REQ-014 mem_to_reg  output  2  writeback select: 0=ALU, 1=mem data, 2=PC+4.
REQ-015 pc_src  output  1  PC source: 0=ALU result, 1=ALU out register.
REQ-016 illegal  output  1  sticky flag: unsupported opcode seen.
REQ-017 mem_err  output  1  sticky flag: memory timeout.
REQ-018 state  output  4  current state, for debug.

Function
REQ-019 States and encodings:
- FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, BRANCH=9, JAL=10, HALT=11.
REQ-020 All outputs except illegal and mem_err are Moore-decoded from state; any output not listed for a state is 0.
REQ-021 FETCH:
- Outputs: mem_read=1, alu_src_a=0, alu_src_b=2, alu_op=0.
- On the mem_ready cycle only: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
- Otherwise stay in FETCH.
REQ-022 DECODE:
- Outputs: alu_src_a=2, alu_src_b=1, alu_op=0 (branch target precompute).
- Dispatch on opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - anything else -> HALT, and set illegal.
REQ-023 EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=2; then WB_ALU.
REQ-024 EXEC_I: alu_src_a=1, alu_src_b=1, alu_op=2; then WB_ALU.
REQ-025 MEM_ADDR: alu_src_a=1, alu_src_b=1, alu_op=0; then MEM_RD if opcode=0000011, else MEM_WR.
REQ-026 MEM_RD: mem_read=1; stay until mem_ready, then WB_MEM.
REQ-027 MEM_WR: mem_write=1; stay until mem_ready, then FETCH.
REQ-028 WB_ALU: reg_write=1, mem_to_reg=0; then FETCH.
REQ-029 WB_MEM: reg_write=1, mem_to_reg=1; then FETCH.
REQ-030 BRANCH:
- Outputs: alu_src_a=1, alu_src_b=0, alu_op=1, pc_src=1.
- pc_write = (funct3=000 & zero) | (funct3=001 & ~zero).
- Other funct3 values: pc_write=0, no flag set.
- Next state FETCH.
REQ-031 JAL: reg_write=1, mem_to_reg=2, pc_write=1, pc_src=1; then FETCH.
REQ-032 HALT: all strobes 0; remain in HALT until reset.
REQ-033 Wait counter:
- 4 bits; cleared on entry to FETCH, MEM_RD or MEM_WR; increments each cycle mem_ready=0 in those states.
- When it reaches MAX_WAIT with mem_ready=0: set mem_err and go to HALT next cycle.
- mem_ready=1 in that same cycle wins: normal transition, no error.
REQ-034 Total latency, zero memory wait:
- R/I 4 cycles, load 5, store 4, branch 3, jal 3.
- Each mem_ready-low cycle adds 1.
REQ-035 illegal and mem_err clear only on reset.

Reset
REQ-036 reset sampled high at a clock edge sets:
- state=FETCH
- wait counter=0
- illegal=0, mem_err=0
REQ-037 Reset overrides every transition, including mid-access in MEM_RD/MEM_WR and in HALT.
- Outputs of the following cycle are FETCH values.
- No write strobe of the aborted instruction is issued after reset.

Verification
REQ-038 add x3,x1,x2 (0x002081B3), mem_ready always 1:
- States 0,1,2,7.
- reg_write=1 only in cycle 4.
- pc_write/ir_write only in cycle 1.
REQ-039 lw x5,8(x1) (0x0080A283), mem_ready low 2 cycles in MEM_RD:
- States 0,1,4,5,5,5,8.
- mem_to_reg=1 with reg_write=1 in the last cycle.
REQ-040 beq with zero=1 -> pc_write=1, pc_src=1 in BRANCH; repeat with zero=0 -> pc_write=0.
REQ-041 Instruction 0x0000007F -> DECODE then HALT, illegal=1, held for 10 cycles.
- Then reset -> FETCH, illegal=0.
REQ-042 mem_ready held 0 in FETCH, MAX_WAIT=15:
- mem_err=1, state=HALT after the 15th wait cycle.
- Repeat with mem_ready=1 on the 15th cycle -> DECODE, mem_err=0.
REQ-043 sw issued, reset asserted in the first MEM_WR cycle:
- Next cycle state=FETCH, mem_write=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V style control unit: Moore-decoded datapath controls with a
// bounded wait on memory handshakes and sticky illegal/timeout flags.
module multicycle_ctrl #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruc,
    input  logic        mem_ready,
    input  logic        zero,
    output logic        pc_write,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  mem_to_reg,
    output logic        pc_src,
    output logic        illegal,
    output logic        mem_err,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        WB_ALU   = 4'd7,
        WB_MEM   = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        HALT     = 4'd11
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_t     cur, nxt;
    logic [3:0] wait_cnt;
    logic       waiting;
    logic       timeout;
    logic       bad_op;
    logic [6:0] opcode;
    logic [2:0] funct3;

    assign opcode  = instruc[6:0];
    assign funct3  = instruc[14:12];
    assign state   = cur;
    assign waiting = (cur == FETCH) || (cur == MEM_RD) || (cur == MEM_WR);
    // This is the MAX_WAIT-th consecutive cycle without mem_ready.
    assign timeout = waiting && !mem_ready && (wait_cnt == 4'(MAX_WAIT - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur      <= FETCH;
            wait_cnt <= '0;
            illegal  <= 1'b0;
            mem_err  <= 1'b0;
        end else begin
            cur <= nxt;
            if (nxt != cur)
                wait_cnt <= '0;
            else if (waiting && !mem_ready)
                wait_cnt <= wait_cnt + 4'd1;
            if (bad_op)
                illegal <= 1'b1;
            if (timeout)
                mem_err <= 1'b1;
        end
    end

    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        nxt        = cur;
        bad_op     = 1'b0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'd0;
        alu_src_b  = 2'd0;
        alu_op     = 2'd0;
        mem_to_reg = 2'd0;
        pc_src     = 1'b0;

        case (cur)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd2;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    nxt      = DECODE;
                end else if (timeout) begin
                    nxt = HALT;
                end
            end
            DECODE: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                case (opcode)
                    OP_R:               nxt = EXEC_R;
                    OP_I:               nxt = EXEC_I;
                    OP_LOAD, OP_STORE:  nxt = MEM_ADDR;
                    OP_BRANCH:          nxt = BRANCH;
                    OP_JAL:             nxt = JAL;
                    default: begin
                        nxt    = HALT;
                        bad_op = 1'b1;
                    end
                endcase
            end
            EXEC_R: begin
                alu_src_a = 2'd1;
                alu_op    = 2'd2;
                nxt       = WB_ALU;
            end
            EXEC_I: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                alu_op    = 2'd2;
                nxt       = WB_ALU;
            end
            MEM_ADDR: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                nxt       = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                if (mem_ready)    nxt = WB_MEM;
                else if (timeout) nxt = HALT;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                if (mem_ready)    nxt = FETCH;
                else if (timeout) nxt = HALT;
            end
            WB_ALU: begin
                reg_write = 1'b1;
                nxt       = FETCH;
            end
            WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'd1;
                nxt        = FETCH;
            end
            BRANCH: begin
                alu_src_a = 2'd1;
                alu_op    = 2'd1;
                pc_src    = 1'b1;
                pc_write  = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
                nxt       = FETCH;
            end
            JAL: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'd2;
                pc_write   = 1'b1;
                pc_src     = 1'b1;
                nxt        = FETCH;
            end
            HALT:    nxt = HALT;
            default: nxt = FETCH;
        endcase
    end

endmodule
